// File: rtl/link_buffer_if.sv
// Link packet definition and the req/ack link interface
// shared by the combiner, link buffer and consumers.
package link_pkg;
   localparam int TIA_TAG_WIDTH  = 3;
   localparam int TIA_WORD_WIDTH = 32;

   typedef struct packed {
      logic [TIA_TAG_WIDTH-1:0]  tag;
      logic [TIA_WORD_WIDTH-1:0] data;
   } packet_t;
endpackage

interface link_if;
   import link_pkg::*;

   logic    req;
   logic    ack;
   packet_t packet;

   modport sender (
      output req,
      output packet,
      input  ack
   );

   modport receiver (
      input  req,
      input  packet,
      output ack
   );

   // Same roles under master/slave naming
   modport master (
      output req,
      output packet,
      input  ack
   );

   modport slave (
      input  req,
      input  packet,
      output ack
   );
endinterface

// File: rtl/link_buffer.sv
// Elastic registered FIFO between the link combiner and its consumer;
// both handshakes are fully decoupled through registered state.
module link_buffer
   import link_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
   input  logic                   clock,
   input  logic                   reset_n,
   link_if.receiver               input_link,
   link_if.sender                 output_link,
   output logic [COUNT_WIDTH-1:0] occupancy
);

   localparam int PTR_WIDTH = $clog2(DEPTH);
   localparam logic [COUNT_WIDTH-1:0] FULL_COUNT =
      COUNT_WIDTH'(DEPTH);

   packet_t mem [DEPTH];

   logic [PTR_WIDTH-1:0]   wr_ptr;
   logic [PTR_WIDTH-1:0]   rd_ptr;
   logic [COUNT_WIDTH-1:0] count;

   logic full;
   logic empty;
   logic push;
   logic pop;

   assign full  = (count == FULL_COUNT);
   assign empty = (count == '0);

   // Ack is held low while in reset so nothing is accepted mid-reset
   assign input_link.ack = reset_n && !full;
   assign output_link.req = !empty;
   assign output_link.packet = empty ? '0 : mem[rd_ptr];
   assign occupancy = count;

   assign push = input_link.req && input_link.ack;
   assign pop  = output_link.req && output_link.ack;

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= input_link.packet;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_WIDTH'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_WIDTH'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + COUNT_WIDTH'(1);
            2'b01:   count <= count - COUNT_WIDTH'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_link_buffer.sv
// Directed bench for link_buffer: reset, single packet, full,
// streaming, simultaneous push/pop and a random scoreboard run.
module tb_link_buffer;
   import link_pkg::*;

   logic       clock;
   logic       reset_n;
   logic [2:0] occupancy;

   int errors;
   int checks;

   link_if in_l ();
   link_if out_l ();

   link_buffer #(.DEPTH(4)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .input_link  (in_l),
      .output_link (out_l),
      .occupancy   (occupancy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(
      input string       tag,
      input logic [63:0] obs,
      input logic [63:0] exp
   );
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   int          mcnt;
   logic [31:0] sb [$];
   logic [31:0] rdata;
   logic        m_push;
   logic        m_pop;

   initial begin
      errors       = 0;
      checks       = 0;
      reset_n      = 1'b0;
      in_l.req     = 1'b0;
      in_l.packet  = '0;
      out_l.ack    = 1'b0;

      // Reset state
      #12;
      check("rst_occ", 64'(occupancy), 0);
      check("rst_oreq", 64'(out_l.req), 0);
      check("rst_iack", 64'(in_l.ack), 0);
      check("rst_pkt", 64'(out_l.packet), 0);
      reset_n = 1'b1;
      #1;
      check("rel_iack", 64'(in_l.ack), 1);
      step();

      // Single packet with output ack low
      in_l.req = 1'b1;
      in_l.packet.tag = 3'd2;
      in_l.packet.data = 32'hDEADBEEF;
      step();
      in_l.req = 1'b0;
      in_l.packet = 'x;
      check("one_oreq", 64'(out_l.req), 1);
      check("one_tag", 64'(out_l.packet.tag), 2);
      check("one_data", 64'(out_l.packet.data), 64'hDEADBEEF);
      check("one_occ", 64'(occupancy), 1);
      step();
      step();
      check("one_hold", 64'(out_l.packet.data), 64'hDEADBEEF);
      check("one_hocc", 64'(occupancy), 1);
      out_l.ack = 1'b1;
      step();
      out_l.ack = 1'b0;
      check("one_occ0", 64'(occupancy), 0);
      check("one_oreq0", 64'(out_l.req), 0);
      check("one_pkt0", 64'(out_l.packet), 0);

      // Fill to full, then a blocked push
      for (int i = 1; i <= 4; i++) begin
         in_l.req = 1'b1;
         in_l.packet.tag = 3'(i);
         in_l.packet.data = 32'(i);
         step();
      end
      check("full_occ", 64'(occupancy), 4);
      check("full_iack", 64'(in_l.ack), 0);
      in_l.packet.tag = 3'd5;
      in_l.packet.data = 32'd5;
      step();
      check("full_blk", 64'(occupancy), 4);
      check("full_head", 64'(out_l.packet.data), 1);
      out_l.ack = 1'b1;
      #1;
      check("full_nbyp", 64'(in_l.ack), 0);
      step();
      out_l.ack = 1'b0;
      check("pop1_occ", 64'(occupancy), 3);
      check("pop1_iack", 64'(in_l.ack), 1);
      step();
      in_l.req = 1'b0;
      check("push5_occ", 64'(occupancy), 4);
      out_l.ack = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         check("order", 64'(out_l.packet.data), 64'(i));
         check("order_tag", 64'(out_l.packet.tag), 64'(i));
         step();
      end
      out_l.ack = 1'b0;
      check("drain_occ", 64'(occupancy), 0);

      // Streaming with a permanently acking consumer
      out_l.ack = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_l.req = 1'b1;
         in_l.packet.tag = 3'(i);
         in_l.packet.data = 32'(100 + i);
         step();
         check("strm_data", 64'(out_l.packet.data), 64'(100 + i));
         check("strm_occ", 64'(occupancy), 1);
      end
      in_l.req = 1'b0;
      step();
      out_l.ack = 1'b0;
      check("strm_end", 64'(occupancy), 0);

      // Simultaneous push/pop at count = DEPTH-1
      for (int i = 0; i < 3; i++) begin
         in_l.req = 1'b1;
         in_l.packet.data = 32'(200 + i);
         step();
      end
      check("d1_occ", 64'(occupancy), 3);
      in_l.packet.data = 32'd203;
      out_l.ack = 1'b1;
      step();
      in_l.req = 1'b0;
      check("d1_same", 64'(occupancy), 3);
      for (int i = 1; i <= 3; i++) begin
         check("d1_order", 64'(out_l.packet.data), 64'(200 + i));
         step();
      end
      out_l.ack = 1'b0;
      check("d1_empty", 64'(occupancy), 0);

      // Reset mid-stream with three entries stored
      for (int i = 0; i < 3; i++) begin
         in_l.req = 1'b1;
         in_l.packet.tag = 3'd7;
         in_l.packet.data = 32'(300 + i);
         step();
      end
      in_l.req = 1'b0;
      check("mid_occ3", 64'(occupancy), 3);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_occ", 64'(occupancy), 0);
      check("mid_oreq", 64'(out_l.req), 0);
      check("mid_tag", 64'(out_l.packet.tag), 0);
      check("mid_data", 64'(out_l.packet.data), 0);
      check("mid_iack", 64'(in_l.ack), 0);
      step();
      reset_n = 1'b1;
      #1;
      check("mid_rel", 64'(in_l.ack), 1);
      in_l.req = 1'b1;
      in_l.packet.tag = 3'd4;
      in_l.packet.data = 32'h1234;
      step();
      in_l.req = 1'b0;
      check("mid_push", 64'(occupancy), 1);
      check("mid_pkt", 64'(out_l.packet.data), 64'h1234);
      out_l.ack = 1'b1;
      step();
      out_l.ack = 1'b0;

      // Random req/ack against a queue scoreboard
      mcnt = 0;
      for (int c = 0; c < 3000; c++) begin
         in_l.req = 1'($urandom_range(0, 1));
         in_l.packet.tag = 3'($urandom);
         in_l.packet.data = $urandom;
         out_l.ack = 1'($urandom_range(0, 1));
         #1;
         check("rnd_iack", 64'(in_l.ack), 64'(mcnt != 4));
         check("rnd_oreq", 64'(out_l.req), 64'(mcnt != 0));
         check("rnd_occ", 64'(occupancy), 64'(mcnt));
         m_push = in_l.req && (mcnt != 4);
         m_pop  = out_l.ack && (mcnt != 0);
         if (m_pop) begin
            rdata = sb.pop_front();
            check("rnd_data", 64'(out_l.packet.data), 64'(rdata));
         end
         if (m_push) sb.push_back(in_l.packet.data);
         mcnt = mcnt + int'(m_push) - int'(m_pop);
         step();
      end
      in_l.req = 1'b0;
      out_l.ack = 1'b0;
      #1;
      check("rnd_fin", 64'(occupancy), 64'(mcnt));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
